pd_pluse_gen: RTL and testbench

- Programmable pulse-train generator on the DDS clock domain.
- Emits `pluse_out` pulses of programmed width and gap, repeated a programmed number of times.
- Drives `stateover`, which is high while a train is active.
- It is the transmitting end of the pulse/duration interface. The downstream pulse-duration timer consumes `pluse_out` and `stateover` and counts DDS cycles while both are high.

---
 rtl/pd_pluse_gen.sv | 176 +++++++++++++++++
 tb/tb_pd_pluse_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pd_pluse_gen.sv
// -----------------------------------------------------------------------------
// pd_pluse_gen -- programmable pulse-train generator (DDS clock domain)
//
// Emits `num` pulses on pluse_out, each `width` dds cycles high, separated by
// max(gap,1) low cycles. stateover is high from the first pulse cycle through
// the last pulse cycle, so a downstream pulse-duration timer gating on it sees
// num*width + (num-1)*max(gap,1) cycles. width/gap/num are latched when a
// start is accepted; later input changes do not affect the running train.
//
// Ports:
//   dds        in   system (DDS) clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   train request, honoured only in IDLE
//   abort      in   synchronous abort, returns to IDLE with all outputs low
//   width      in   [CW-1:0] pulse high time (dds cycles)
//   gap        in   [CW-1:0] low time between pulses (0 behaves as 1)
//   num        in   [NW-1:0] pulses per train
//   pluse_out  out  generated pulse (registered)
//   stateover  out  train-active window (registered)
//   busy       out  high in any state other than IDLE (registered)
//   done       out  one-cycle strobe on normal completion (registered)
//   pulse_cnt  out  [NW-1:0] pulses completed in current/last train
//                   (present only when PD_PLUSE_GEN_CNT_EN is defined)
//
// Build option: define PD_PLUSE_GEN_CNT_EN to add the pulse_cnt output.
// -----------------------------------------------------------------------------
module pd_pluse_gen #(
    parameter int CW = 16,
    parameter int NW = 8
) (
    input  logic          dds,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] gap,
    input  logic [NW-1:0] num,
    output logic          pluse_out,
    output logic          stateover,
    output logic          busy,
    output logic          done
`ifdef PD_PLUSE_GEN_CNT_EN
    ,
    output logic [NW-1:0] pulse_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] width_q, width_nxt;
    logic [CW-1:0] gap_q,   gap_nxt;
    logic [NW-1:0] rem_q,   rem_nxt;
    logic [CW-1:0] wcnt_q,  wcnt_nxt;   // counts 1..width inside PULSE
    logic [CW-1:0] gcnt_q,  gcnt_nxt;   // counts 1..max(gap,1) inside GAP
    logic [CW-1:0] gap_eff;
    logic          accept;
    logic          pulse_last;

    // A zero gap still yields one low cycle so consecutive pulses stay separated.
    assign gap_eff    = (gap_q == '0) ? CW'(1) : gap_q;
    assign accept     = (state == IDLE) && start && !abort;
    // Counters compare for equality against latched limits and are reloaded
    // before they could ever pass 2^CW-1, so they never wrap.
    assign pulse_last = (state == PULSE) && (wcnt_q == width_q);

    // Next-state and next-datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        width_nxt = width_q;
        gap_nxt   = gap_q;
        rem_nxt   = rem_q;
        wcnt_nxt  = wcnt_q;
        gcnt_nxt  = gcnt_q;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    width_nxt = width;
                    gap_nxt   = gap;
                    rem_nxt   = num;
                    if ((width == '0) || (num == '0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PULSE;
                        wcnt_nxt  = CW'(1);
                    end
                end
            end
            PULSE: begin
                if (pulse_last) begin
                    rem_nxt = rem_q - NW'(1);
                    if (rem_q > NW'(1)) begin
                        state_nxt = GAP;
                        gcnt_nxt  = CW'(1);
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    wcnt_nxt = wcnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gcnt_q == gap_eff) begin
                    state_nxt = PULSE;
                    wcnt_nxt  = CW'(1);
                end else begin
                    gcnt_nxt = gcnt_q + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over every transition except reset.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // State, datapath and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state they describe.
    always_ff @(posedge dds or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            width_q   <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            wcnt_q    <= '0;
            gcnt_q    <= '0;
            pluse_out <= 1'b0;
            stateover <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state     <= state_nxt;
            width_q   <= width_nxt;
            gap_q     <= gap_nxt;
            rem_q     <= rem_nxt;
            wcnt_q    <= wcnt_nxt;
            gcnt_q    <= gcnt_nxt;
            pluse_out <= (state_nxt == PULSE);
            stateover <= (state_nxt == PULSE) || (state_nxt == GAP);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
        end
    end

`ifdef PD_PLUSE_GEN_CNT_EN
    // Completed-pulse counter: cleared on an accepted start, bumped on the
    // last cycle of each pulse unless that cycle is aborted, held otherwise.
    always_ff @(posedge dds or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else if (accept) begin
            pulse_cnt <= '0;
        end else if (pulse_last && !abort) begin
            pulse_cnt <= pulse_cnt + NW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pd_pluse_gen.sv
// -----------------------------------------------------------------------------
// tb_pd_pluse_gen -- directed self-checking bench for pd_pluse_gen.
// Inputs are driven and outputs sampled 1 ns after each rising dds edge.
// Output bundle compared as {pluse_out, stateover, busy, done}.
// -----------------------------------------------------------------------------
module tb_pd_pluse_gen;

    localparam int CW = 16;
    localparam int NW = 8;

    logic          dds = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] width;
    logic [CW-1:0] gap;
    logic [NW-1:0] num;
    logic          pluse_out;
    logic          stateover;
    logic          busy;
    logic          done;
`ifdef PD_PLUSE_GEN_CNT_EN
    logic [NW-1:0] pulse_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pd_pluse_gen #(.CW(CW), .NW(NW)) dut (
        .dds       (dds),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .width     (width),
        .gap       (gap),
        .num       (num),
        .pluse_out (pluse_out),
        .stateover (stateover),
        .busy      (busy),
        .done      (done)
`ifdef PD_PLUSE_GEN_CNT_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 dds = ~dds;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge dds);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {pluse_out, stateover, busy, done};
    endfunction

    // Present a start for one sampling edge; returns in the first cycle after it.
    task automatic start_train(input int w, input int g, input int n);
        width = CW'(w);
        gap   = CW'(g);
        num   = NW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit exp_p4 [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
        bit exp_p5 [7] = '{1, 1, 0, 0, 1, 1, 0};
        int  np;
        int  ns;
        bit  seen;
        logic [3:0] e;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        width = '0; gap = '0; num = '0;

        // ---- Reset, idle, asynchronous reset mid-pulse ----
        repeat (3) tick();
        check("rst_outs", outs(), 4'b0000);
`ifdef PD_PLUSE_GEN_CNT_EN
        check("rst_cnt", pulse_cnt, 0);
`endif
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 4'b0000);
        start_train(4, 1, 2);
        check("t1_first_pulse", outs(), 4'b1110);
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("t1_async_rst", outs(), 4'b0000);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("t1_idle_after_rst", outs(), 4'b0000);

        // ---- width=5 gap=3 num=3; inputs disturbed mid-train ----
        start_train(5, 3, 3);
        for (int i = 1; i <= 23; i++) begin
            e[3] = (i inside {[1:5], [9:13], [17:21]});
            e[2] = (i <= 21);
            e[1] = (i <= 22);
            e[0] = (i == 22);
            check($sformatf("t2_c%0d", i), outs(), e);
            if (i == 3) begin
                width = 16'd9; gap = 16'd1; num = 8'd7;
            end
            tick();
        end

        // ---- zero width / zero num: no pulse, immediate done ----
        start_train(0, 3, 3);
        check("t3_w0_done", outs(), 4'b0011);
        tick();
        check("t3_w0_idle", outs(), 4'b0000);
        start_train(4, 3, 0);
        check("t3_n0_done", outs(), 4'b0011);
        tick();
        check("t3_n0_idle", outs(), 4'b0000);

        // ---- width=2 gap=0 num=2; start while busy is ignored ----
        start_train(2, 0, 2);
        for (int i = 1; i <= 8; i++) begin
            e[3] = exp_p4[i-1];
            e[2] = (i <= 5);
            e[1] = (i <= 6);
            e[0] = (i == 6);
            check($sformatf("t4_c%0d", i), outs(), e);
            start = (i == 3);
            tick();
        end
        start = 1'b0;

        // ---- abort in second gap of num=4, then immediate restart ----
        start_train(2, 2, 4);
        for (int i = 1; i <= 7; i++) begin
            e[3] = exp_p5[i-1];
            e[2] = 1'b1;
            e[1] = 1'b1;
            e[0] = 1'b0;
            check($sformatf("t5_c%0d", i), outs(), e);
            abort = (i == 7);
            tick();
        end
        abort = 1'b0;
        check("t5_abort_outs", outs(), 4'b0000);
`ifdef PD_PLUSE_GEN_CNT_EN
        check("t5_cnt_after_abort", pulse_cnt, 2);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart", outs(), 4'b1110);
`ifdef PD_PLUSE_GEN_CNT_EN
        check("t5_cnt_cleared", pulse_cnt, 0);
`endif
        np = 0; ns = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (pluse_out) np++;
            if (stateover) ns++;
            if (done) seen = 1'b1;
            else tick();
        end
        check("t5_done_seen", 32'(seen), 1);
        check("t5_pulse_cycles", np, 8);
        check("t5_stateover_cycles", ns, 14);
        tick();
        check("t5_idle_after", outs(), 4'b0000);
`ifdef PD_PLUSE_GEN_CNT_EN
        check("t5_cnt_full", pulse_cnt, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
